// File: rtl/rf_wb_sched.sv
// rf_wb_sched: write-back scheduler and register scoreboard.
// Two write-back sources share the single RF write port through a round-robin
// arbiter. A busy bit per register holds back issue on RAW and WAW hazards.
module rf_wb_sched #(
  parameter int DW = 32,
  parameter int AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_vld,
  input  logic              iss_wen,
  input  logic [AW-1:0]     iss_rd,
  input  logic [AW-1:0]     iss_rs1,
  input  logic [AW-1:0]     iss_rs2,
  output logic              iss_stall,
  input  logic              wb0_vld,
  input  logic [AW-1:0]     wb0_addr,
  input  logic [DW-1:0]     wb0_data,
  output logic              wb0_rdy,
  input  logic              wb1_vld,
  input  logic [AW-1:0]     wb1_addr,
  input  logic [DW-1:0]     wb1_data,
  output logic              wb1_rdy,
  output logic              rf_en4w,
  output logic [AW-1:0]     rf_addr_w0,
  output logic [DW-1:0]     rf_data_i0,
  output logic [(1<<AW)-1:0] busy,
  output logic              wb_err
);

  localparam int NR = 1 << AW;

  logic [NR-1:0] busy_r;
  logic          rr_ptr_r;   // 0: WB0 wins a tie, 1: WB1 wins a tie
  logic          wb_err_r;

  logic          gnt0_s;
  logic          gnt1_s;
  logic          any_gnt_s;
  logic [AW-1:0] wa_s;
  logic [DW-1:0] wd_s;
  logic          wen_s;
  logic          stall_s;
  logic          iss_set_s;
  logic [NR-1:0] clr_mask_s;
  logic [NR-1:0] set_mask_s;

  // Round-robin grant between the two write-back sources and write-port mux.
  always_comb begin
    gnt0_s = 1'b0;
    gnt1_s = 1'b0;
    if (wb0_vld && wb1_vld) begin
      gnt0_s = ~rr_ptr_r;
      gnt1_s = rr_ptr_r;
    end else begin
      gnt0_s = wb0_vld;
      gnt1_s = wb1_vld;
    end
    any_gnt_s = gnt0_s | gnt1_s;
    wa_s      = gnt1_s ? wb1_addr : wb0_addr;
    wd_s      = gnt1_s ? wb1_data : wb0_data;
    // x0 is hard-wired zero: the request is accepted but nothing is written.
    wen_s     = any_gnt_s & (wa_s != {AW{1'b0}});
  end

  // Hazard check against registered busy bits and the resulting scoreboard edits.
  always_comb begin
    stall_s    = iss_vld & (busy_r[iss_rs1] | busy_r[iss_rs2] | (iss_wen & busy_r[iss_rd]));
    iss_set_s  = iss_vld & ~stall_s & iss_wen & (iss_rd != {AW{1'b0}});
    clr_mask_s = wen_s     ? ({{(NR-1){1'b0}}, 1'b1} << wa_s)   : {NR{1'b0}};
    set_mask_s = iss_set_s ? ({{(NR-1){1'b0}}, 1'b1} << iss_rd) : {NR{1'b0}};
  end

  // Scoreboard, arbitration pointer and sticky error state.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r   <= {NR{1'b0}};
      rr_ptr_r <= 1'b0;
      wb_err_r <= 1'b0;
    end else begin
      // Clear first, then set: a new reservation wins over a same-cycle write-back.
      busy_r <= (busy_r & ~clr_mask_s) | set_mask_s;
      if (any_gnt_s) begin
        // Point at the source that did not get the port this cycle.
        rr_ptr_r <= gnt0_s;
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
      wb_err_r <= wb_err_r | (wen_s & ~busy_r[wa_s]);
    end
  end

  assign iss_stall  = stall_s;
  assign wb0_rdy    = gnt0_s;
  assign wb1_rdy    = gnt1_s;
  assign rf_en4w    = wen_s;
  assign rf_addr_w0 = wa_s;
  assign rf_data_i0 = wd_s;
  assign busy       = busy_r;
  assign wb_err     = wb_err_r;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Directed self-checking bench for rf_wb_sched.
module tb_rf_wb_sched;

  localparam int DW = 32;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic          iss_vld, iss_wen;
  logic [AW-1:0] iss_rd, iss_rs1, iss_rs2;
  logic          iss_stall;
  logic          wb0_vld, wb1_vld;
  logic [AW-1:0] wb0_addr, wb1_addr;
  logic [DW-1:0] wb0_data, wb1_data;
  logic          wb0_rdy, wb1_rdy;
  logic          rf_en4w;
  logic [AW-1:0] rf_addr_w0;
  logic [DW-1:0] rf_data_i0;
  logic [31:0]   busy;
  logic          wb_err;

  int checks = 0;
  int errors = 0;

  rf_wb_sched #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .iss_vld(iss_vld), .iss_wen(iss_wen), .iss_rd(iss_rd),
    .iss_rs1(iss_rs1), .iss_rs2(iss_rs2), .iss_stall(iss_stall),
    .wb0_vld(wb0_vld), .wb0_addr(wb0_addr), .wb0_data(wb0_data), .wb0_rdy(wb0_rdy),
    .wb1_vld(wb1_vld), .wb1_addr(wb1_addr), .wb1_data(wb1_data), .wb1_rdy(wb1_rdy),
    .rf_en4w(rf_en4w), .rf_addr_w0(rf_addr_w0), .rf_data_i0(rf_data_i0),
    .busy(busy), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    iss_vld = 1'b0; iss_wen = 1'b0; iss_rd = 5'd0; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    wb0_vld = 1'b0; wb0_addr = 5'd0; wb0_data = 32'h0;
    wb1_vld = 1'b0; wb1_addr = 5'd0; wb1_data = 32'h0;
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic reserve(input logic [AW-1:0] rd);
    iss_vld = 1'b1; iss_wen = 1'b1; iss_rd = rd; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    step();
    iss_vld = 1'b0; iss_wen = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp %h", busy, 32'h0); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL reset_wb_err got %b exp 0", wb_err); end
    checks++; if ({iss_stall, wb0_rdy, wb1_rdy, rf_en4w} !== 4'b0000) begin errors++;
      $display("FAIL reset_idle_outs got %b exp 0000", {iss_stall, wb0_rdy, wb1_rdy, rf_en4w}); end
  endtask

  task automatic test_raw_waw();
    iss_vld = 1'b1; iss_wen = 1'b1; iss_rd = 5'd5; iss_rs1 = 5'd0; iss_rs2 = 5'd0;
    #1;
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue stall got %b exp 0", iss_stall); end
    step();
    iss_wen = 1'b0; iss_rs1 = 5'd5;
    #1;
    checks++; if (busy !== 32'h0000_0020) begin errors++; $display("FAIL raw_busy5 got %h exp %h", busy, 32'h20); end
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_rs1 stall got %b exp 1", iss_stall); end
    iss_rs1 = 5'd0; iss_rs2 = 5'd5;
    #1;
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL raw_rs2 stall got %b exp 1", iss_stall); end
    iss_rs2 = 5'd0; iss_wen = 1'b1; iss_rd = 5'd5;
    #1;
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL waw_rd stall got %b exp 1", iss_stall); end
    iss_vld = 1'b0;
    #1;
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL novld stall got %b exp 0", iss_stall); end
    step();
    checks++; if (busy !== 32'h0000_0020) begin errors++; $display("FAIL stalled_no_set got %h exp %h", busy, 32'h20); end
  endtask

  task automatic test_wb_commit();
    wb0_vld = 1'b1; wb0_addr = 5'd5; wb0_data = 32'hDEADBEEF;
    iss_vld = 1'b1; iss_wen = 1'b0; iss_rs1 = 5'd5; iss_rs2 = 5'd0;
    #1;
    checks++; if ({wb0_rdy, wb1_rdy, rf_en4w} !== 3'b101) begin errors++;
      $display("FAIL wb_commit_ctl got %b exp 101", {wb0_rdy, wb1_rdy, rf_en4w}); end
    checks++; if (rf_addr_w0 !== 5'd5 || rf_data_i0 !== 32'hDEADBEEF) begin errors++;
      $display("FAIL wb_commit_port got %0d/%h exp 5/deadbeef", rf_addr_w0, rf_data_i0); end
    checks++; if (iss_stall !== 1'b1) begin errors++; $display("FAIL no_forwarding stall got %b exp 1", iss_stall); end
    step();
    wb0_vld = 1'b0;
    #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL wb_clear busy got %h exp 0", busy); end
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL after_wb stall got %b exp 0", iss_stall); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL wb_commit_err got %b exp 0", wb_err); end
    iss_vld = 1'b0;
  endtask

  task automatic test_round_robin();
    pulse_reset();
    reserve(5'd3);
    reserve(5'd4);
    checks++; if (busy !== 32'h0000_0018) begin errors++; $display("FAIL rr_reserve got %h exp %h", busy, 32'h18); end
    wb0_vld = 1'b1; wb0_addr = 5'd3; wb0_data = 32'h3333_0000;
    wb1_vld = 1'b1; wb1_addr = 5'd4; wb1_data = 32'h4444_0000;
    #1;
    checks++; if ({wb0_rdy, wb1_rdy} !== 2'b10) begin errors++; $display("FAIL rr_cycle1 rdy got %b exp 10", {wb0_rdy, wb1_rdy}); end
    checks++; if (rf_addr_w0 !== 5'd3 || rf_data_i0 !== 32'h3333_0000) begin errors++;
      $display("FAIL rr_cycle1 port got %0d/%h exp 3/33330000", rf_addr_w0, rf_data_i0); end
    step();
    // WB0 keeps its (already served) request up; the pointer now favours WB1.
    #1;
    checks++; if ({wb0_rdy, wb1_rdy} !== 2'b01) begin errors++; $display("FAIL rr_cycle2 rdy got %b exp 01", {wb0_rdy, wb1_rdy}); end
    checks++; if (rf_addr_w0 !== 5'd4 || rf_data_i0 !== 32'h4444_0000 || rf_en4w !== 1'b1) begin errors++;
      $display("FAIL rr_cycle2 port got %0d/%h/%b exp 4/44440000/1", rf_addr_w0, rf_data_i0, rf_en4w); end
    step();
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL rr_busy_done got %h exp 0", busy); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL rr_err got %b exp 0", wb_err); end
    // Fresh tie: back to WB0. Looked at only, withdrawn before the edge.
    #1;
    checks++; if ({wb0_rdy, wb1_rdy} !== 2'b10) begin errors++; $display("FAIL rr_cycle3 rdy got %b exp 10", {wb0_rdy, wb1_rdy}); end
    wb0_vld = 1'b0; wb1_vld = 1'b0;
  endtask

  task automatic test_same_cycle();
    reserve(5'd7);
    // Write-back of r7 alongside an issue targeting r7: the issue sees the old
    // busy bit (no forwarding) so it stalls, and the write-back frees r7.
    wb1_vld = 1'b1; wb1_addr = 5'd7; wb1_data = 32'h7777_7777;
    iss_vld = 1'b1; iss_wen = 1'b1; iss_rd = 5'd7;
    #1;
    checks++; if ({wb1_rdy, rf_en4w, iss_stall} !== 3'b111) begin errors++;
      $display("FAIL same_cycle_ctl got %b exp 111", {wb1_rdy, rf_en4w, iss_stall}); end
    step();
    wb1_vld = 1'b0;
    #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL same_cycle_busy got %h exp 0", busy); end
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL same_cycle_err got %b exp 0", wb_err); end
    checks++; if (iss_stall !== 1'b0) begin errors++; $display("FAIL same_cycle_reissue stall got %b exp 0", iss_stall); end
    step();
    iss_vld = 1'b0; iss_wen = 1'b0;
    checks++; if (busy !== 32'h0000_0080) begin errors++; $display("FAIL same_cycle_reissue busy got %h exp %h", busy, 32'h80); end
  endtask

  task automatic test_x0_and_err();
    wb0_vld = 1'b1; wb0_addr = 5'd0; wb0_data = 32'h1234_5678;
    #1;
    checks++; if ({wb0_rdy, rf_en4w} !== 2'b10) begin errors++; $display("FAIL x0_ctl got %b exp 10", {wb0_rdy, rf_en4w}); end
    step();
    // Pointer now favours WB1. WB1 writes r9, which is not reserved, while an
    // issue reserves r9 in the same cycle: the new reservation survives.
    wb1_vld = 1'b1; wb1_addr = 5'd9; wb1_data = 32'h9999_0009;
    iss_vld = 1'b1; iss_wen = 1'b1; iss_rd = 5'd9;
    #1;
    checks++; if ({wb0_rdy, wb1_rdy} !== 2'b01) begin errors++; $display("FAIL x0_rotate rdy got %b exp 01", {wb0_rdy, wb1_rdy}); end
    checks++; if (rf_en4w !== 1'b1 || rf_addr_w0 !== 5'd9 || iss_stall !== 1'b0) begin errors++;
      $display("FAIL err_write got en=%b addr=%0d stall=%b exp 1/9/0", rf_en4w, rf_addr_w0, iss_stall); end
    step();
    wb1_vld = 1'b0; wb0_vld = 1'b0; iss_vld = 1'b0; iss_wen = 1'b0;
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_set got %b exp 1", wb_err); end
    checks++; if (busy !== 32'h0000_0280) begin errors++; $display("FAIL set_wins busy got %h exp %h", busy, 32'h280); end
    step();
    step();
    checks++; if (wb_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", wb_err); end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    checks++; if (wb_err !== 1'b0) begin errors++; $display("FAIL rst_clears_err got %b exp 0", wb_err); end
    reserve(5'd4);
    reserve(5'd5);
    reserve(5'd6);
    reserve(5'd7);
    checks++; if (busy !== 32'h0000_00F0) begin errors++; $display("FAIL mid_busy got %h exp %h", busy, 32'hF0); end
    // x0 write-back to move the pointer to WB1 without touching busy.
    wb0_vld = 1'b1; wb0_addr = 5'd0;
    step();
    wb0_addr = 5'd4; wb0_data = 32'hAAAA_0004;
    wb1_vld = 1'b1; wb1_addr = 5'd5; wb1_data = 32'hBBBB_0005;
    #1;
    checks++; if ({wb0_rdy, wb1_rdy} !== 2'b01) begin errors++; $display("FAIL mid_pre_rst rdy got %b exp 01", {wb0_rdy, wb1_rdy}); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    checks++; if (busy !== 32'h0) begin errors++; $display("FAIL mid_rst_busy got %h exp 0", busy); end
    checks++; if ({wb0_rdy, wb1_rdy} !== 2'b10) begin errors++; $display("FAIL mid_rst_grant got %b exp 10", {wb0_rdy, wb1_rdy}); end
    checks++; if (rf_addr_w0 !== 5'd4 || rf_data_i0 !== 32'hAAAA_0004) begin errors++;
      $display("FAIL mid_rst_port got %0d/%h exp 4/aaaa0004", rf_addr_w0, rf_data_i0); end
    idle_inputs();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_raw_waw();
    test_wb_commit();
    test_round_robin();
    test_same_cycle();
    test_x0_and_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
